// File: rtl/scene_pkg.sv
// Shared encodings and screen constants for the parallax scene renderer.
package scene_pkg;

    localparam int COLOR_W       = 12;
    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int LAYER_FIELD_W = 10;

    typedef enum logic [1:0] {
        GAME_INITIAL = 2'd0,
        GAME_PLAYING = 2'd1,
        GAME_OVER    = 2'd2
    } game_state_e;

endpackage

// File: rtl/scroll_layer_addr.sv
// One scrolling layer: pending/active offsets, column phase and row base,
// producing a registered ROM address and band-hit bit per pixel.
module scroll_layer_addr
    import scene_pkg::*;
#(
    parameter int          X_W    = 10,
    parameter int          Y_W    = 9,
    parameter int          ADDR_W = 16,
    parameter int unsigned Y0     = 286,
    parameter int unsigned H      = 80,
    parameter int unsigned WRAP   = 278,
    parameter int unsigned SPEED  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [1:0]        game_state,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              hit
);

    localparam logic [X_W:0] WRAP_X = (X_W+1)'(WRAP);

    logic [X_W-1:0]    pend_q, pend_d, act_q, act_d, phase_q, phase_d;
    logic [ADDR_W-1:0] row_q, row_d, addr_q, addr_d;
    logic              hit_q, hit_d;
    logic [X_W:0]      sum;
    logic [31:0]       y_u;
    logic              in_band;

    assign y_u     = 32'(y);
    assign in_band = (y_u >= Y0) && (y_u < Y0 + H);

    always_comb begin
        pend_d  = pend_q;
        act_d   = act_q;
        phase_d = phase_q;
        row_d   = row_q;
        addr_d  = addr_q;
        hit_d   = 1'b0;
        sum     = {1'b0, pend_q} + (X_W+1)'(SPEED);

        if (tick) begin
            case (game_state)
                GAME_INITIAL: pend_d = '0;
                GAME_PLAYING: pend_d = (sum >= WRAP_X) ? X_W'(sum - WRAP_X) : sum[X_W-1:0];
                default: ;
            endcase
        end

        // The latch at (0,0) takes the old pending value; a tick on that
        // same cycle only lands in the next frame.
        if (frame_start)
            act_d = pend_q;

        if (pix_valid) begin
            if (x == '0) begin
                phase_d = frame_start ? pend_q : act_q;
                if (y_u == Y0)
                    row_d = '0;
                else if (in_band)
                    row_d = row_q + ADDR_W'(WRAP);
            end else begin
                phase_d = (phase_q == X_W'(WRAP - 1)) ? '0 : phase_q + X_W'(1);
            end
            if (in_band) begin
                addr_d = row_d + ADDR_W'(phase_d);
                hit_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            act_q   <= '0;
            phase_q <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            act_q   <= act_d;
            phase_q <= phase_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            hit_q   <= hit_d;
        end
    end

    assign addr = addr_q;
    assign hit  = hit_q;

endmodule

// File: rtl/scene_layer_scroller.sv
// Multi-layer parallax renderer: per-layer address generators, day/night bank
// selection, and priority compositing with a colour key (3-cycle latency).
module scene_layer_scroller
    import scene_pkg::*;
#(
    parameter int                             N_LAYERS    = 2,
    parameter int                             X_W         = 10,
    parameter int                             Y_W         = 9,
    parameter int                             ADDR_W      = 16,
    parameter int                             COLOR_W     = scene_pkg::COLOR_W,
    parameter logic [N_LAYERS*10-1:0]         LAYER_Y0    = {10'd400, 10'd286},
    parameter logic [N_LAYERS*10-1:0]         LAYER_H     = {10'd80, 10'd80},
    parameter logic [N_LAYERS*10-1:0]         LAYER_WRAP  = {10'd24, 10'd278},
    parameter logic [N_LAYERS*10-1:0]         LAYER_SPEED = {10'd2, 10'd1},
    parameter logic [COLOR_W-1:0]             SKY_COLOR   = 12'hCC4,
    parameter logic [COLOR_W-1:0]             KEY_COLOR   = 12'h000,
    parameter int                             CYCLE_TICKS = 3000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [1:0]                   game_state,
    input  logic                         pix_valid,
    input  logic [X_W-1:0]               x,
    input  logic [Y_W-1:0]               y,
    output logic [N_LAYERS*ADDR_W-1:0]   rom_addr,
    output logic                         rom_bank,
    input  logic [N_LAYERS*COLOR_W-1:0]  rom_data,
    output logic                         out_valid,
    output logic [COLOR_W-1:0]           out_data
);

    localparam int FW    = LAYER_FIELD_W;
    localparam int CNT_W = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;

    logic                frame_start;
    logic [N_LAYERS-1:0] hit1, hit2_q, hit2_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                night_q, night_d, bank_q, bank_d;
    logic [2:0]          vld_pipe_q, vld_pipe_d;
    logic [COLOR_W-1:0]  out_data_q, out_data_d, pix, lyr_px;

    assign frame_start = pix_valid && (x == '0) && (y == '0);

    for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_layer
        scroll_layer_addr #(
            .X_W    (X_W),
            .Y_W    (Y_W),
            .ADDR_W (ADDR_W),
            .Y0     (LAYER_Y0[gi*FW +: FW]),
            .H      (LAYER_H[gi*FW +: FW]),
            .WRAP   (LAYER_WRAP[gi*FW +: FW]),
            .SPEED  (LAYER_SPEED[gi*FW +: FW])
        ) u_layer (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .game_state  (game_state),
            .frame_start (frame_start),
            .pix_valid   (pix_valid),
            .x           (x),
            .y           (y),
            .addr        (rom_addr[gi*ADDR_W +: ADDR_W]),
            .hit         (hit1[gi])
        );
    end

    always_comb begin
        cnt_d   = cnt_q;
        night_d = night_q;
        bank_d  = bank_q;
        if (tick) begin
            case (game_state)
                GAME_INITIAL: begin
                    cnt_d   = '0;
                    night_d = 1'b0;
                end
                GAME_PLAYING: begin
                    if (cnt_q == CNT_W'(CYCLE_TICKS - 1)) begin
                        cnt_d   = '0;
                        night_d = ~night_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
        if (frame_start)
            bank_d = night_q;
    end

    // Ascending scan: the last qualifying layer is the frontmost one.
    always_comb begin
        pix    = SKY_COLOR;
        lyr_px = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            lyr_px = rom_data[i*COLOR_W +: COLOR_W];
            if (hit2_q[i] && (lyr_px != KEY_COLOR))
                pix = lyr_px;
        end
        vld_pipe_d = {vld_pipe_q[1:0], pix_valid};
        hit2_d     = hit1;
        out_data_d = vld_pipe_q[1] ? pix : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            night_q    <= 1'b0;
            bank_q     <= 1'b0;
            vld_pipe_q <= '0;
            hit2_q     <= '0;
            out_data_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            night_q    <= night_d;
            bank_q     <= bank_d;
            vld_pipe_q <= vld_pipe_d;
            hit2_q     <= hit2_d;
            out_data_q <= out_data_d;
        end
    end

    assign rom_bank  = bank_q;
    assign out_valid = vld_pipe_q[2];
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_scene_layer_scroller.sv
// Self-checking bench: step table of game states/ticks, one frame per step,
// with a pixel scoreboard and a registered ROM model per layer.
module tb_scene_layer_scroller;
    import scene_pkg::*;

    localparam int NL = 2;
    localparam int AW = 16;
    localparam int CW = 12;
    localparam logic [11:0] SKY = 12'hCC4;
    localparam logic [11:0] KEY = 12'h000;
    localparam int Y0[2] = '{286, 400};
    localparam int HT[2] = '{150, 80};
    localparam int WR[2] = '{278, 24};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [1:0]    game_state = 2'd0;
    logic          pix_valid = 1'b0;
    logic [9:0]    x = '0;
    logic [8:0]    y = '0;
    logic [31:0]   rom_addr;
    logic          rom_bank;
    logic [23:0]   rom_data;
    logic          out_valid;
    logic [11:0]   out_data;

    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    logic [2:0]    pv_hist = '0;
    logic [11:0]   sb[$];
    logic [11:0]   exp_d;
    int            cur_off[2];
    bit            cur_bank;

    typedef struct {
        logic [1:0] gs;
        int         ticks;
        int         off0;
        int         off1;
        bit         bank;
        bit         mid_tick;
        bit         fs_tick;
    } step_t;

    step_t steps[10];

    always #5 clk = ~clk;

    scene_layer_scroller #(
        .LAYER_H     ({10'd80, 10'd150}),
        .CYCLE_TICKS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .game_state (game_state),
        .pix_valid  (pix_valid),
        .x          (x),
        .y          (y),
        .rom_addr   (rom_addr),
        .rom_bank   (rom_bank),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_data   (out_data)
    );

    function automatic logic [11:0] rom_val(int i, logic [15:0] a, logic b);
        if (i == 0 && a[3:0] == 4'd9) return KEY;
        if (i == 1 && a[2:0] == 3'd5) return KEY;
        return {2'(i + 1), b, a[8:0]};
    endfunction

    always @(posedge clk)
        for (int i = 0; i < NL; i++)
            rom_data[i*CW +: CW] <= rom_val(i, rom_addr[i*AW +: AW], rom_bank);

    function automatic bit in_band(int i, int yy);
        return (yy >= Y0[i]) && (yy < Y0[i] + HT[i]);
    endfunction

    function automatic logic [31:0] exp_addr(int i, int xx, int yy);
        return 32'((yy - Y0[i]) * WR[i] + (cur_off[i] + xx) % WR[i]);
    endfunction

    function automatic logic [11:0] exp_pix(int xx, int yy);
        logic [31:0] a;
        logic [11:0] d;
        for (int i = NL - 1; i >= 0; i--) begin
            if (in_band(i, yy)) begin
                a = exp_addr(i, xx, yy);
                d = rom_val(i, a[15:0], cur_bank);
                if (d != KEY) return d;
            end
        end
        return SKY;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk)
        pv_hist <= rst ? 3'b000 : {pv_hist[1:0], pix_valid};

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(pv_hist[2]));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: out_data %0h with nothing expected", out_data);
                end else begin
                    exp_d = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(exp_d));
                end
            end
        end
    end

    task automatic drive(bit v, int xx, int yy, bit tk);
        pix_valid = v;
        x         = 10'(xx);
        y         = 9'(yy);
        tick      = tk;
        if (v) sb.push_back(exp_pix(xx, yy));
        @(posedge clk);
        #1;
        tick      = 1'b0;
        pix_valid = 1'b0;
        if (v)
            for (int i = 0; i < NL; i++)
                if (in_band(i, yy))
                    chk("rom_addr", 32'(rom_addr[i*AW +: AW]), exp_addr(i, xx, yy));
    endtask

    task automatic run_frame(step_t r);
        int nx;
        cur_off[0] = r.off0;
        cur_off[1] = r.off1;
        cur_bank   = r.bank;
        drive(1'b1, 0, 0, r.fs_tick);
        chk("rom_bank", 32'(rom_bank), 32'(r.bank));
        for (int yy = 286; yy < 480; yy++) begin
            nx = (yy == 300) ? 290 : ((yy == 420) ? 60 : 20);
            for (int xx = 0; xx < nx; xx++) begin
                if ($urandom_range(7) == 0)
                    drive(1'b0, int'($urandom_range(639)), int'($urandom_range(479)), 1'b0);
                drive(1'b1, xx, yy, r.mid_tick && yy == 420 && xx == 3);
            end
        end
        repeat (4) drive(1'b0, 0, 0, 1'b0);
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // gs, pre-frame ticks, expected offsets and bank for that frame
        steps[0] = '{2'd0,   0,  0,  0, 1'b0, 1'b0, 1'b0};
        steps[1] = '{2'd1, 300, 22,  0, 1'b1, 1'b0, 1'b0};
        steps[2] = '{2'd1,  11, 33, 22, 1'b1, 1'b1, 1'b0};
        steps[3] = '{2'd1,   0, 34,  0, 1'b0, 1'b0, 1'b1};
        steps[4] = '{2'd1,   1, 36,  4, 1'b0, 1'b0, 1'b0};
        steps[5] = '{2'd2,   5, 36,  4, 1'b0, 1'b0, 1'b0};
        steps[6] = '{2'd1,   3, 39, 10, 1'b1, 1'b0, 1'b0};
        steps[7] = '{2'd3,   3, 39, 10, 1'b1, 1'b0, 1'b0};
        steps[8] = '{2'd0,   1,  0,  0, 1'b0, 1'b0, 1'b0};
        steps[9] = '{2'd1,   3,  3,  6, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rom_addr", rom_addr, 32'd0);
        chk("reset_rom_bank", 32'(rom_bank), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int s = 0; s < 10; s++) begin
            game_state = steps[s].gs;
            repeat (steps[s].ticks) drive(1'b0, 0, 0, 1'b1);
            run_frame(steps[s]);
        end

        // Reset in the middle of a line with the pipeline full.
        game_state = 2'd1;
        for (int xx = 0; xx < 10; xx++) drive(1'b1, xx, 200, 1'b0);
        rst       = 1'b1;
        pix_valid = 1'b1;
        x         = 10'd10;
        y         = 9'd200;
        @(posedge clk);
        #1;
        sb.delete();
        rst       = 1'b0;
        pix_valid = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rom_addr", rom_addr, 32'd0);
        chk("rst_rom_bank", 32'(rom_bank), 32'd0);
        game_state = 2'd0;
        run_frame('{2'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scene_layer_scroller.md
Name: scene_layer_scroller

Overview:
- Parametrised multi-layer parallax scene renderer; successor to the fixed two-band scene mapper.
- Sits between the VGA raster scan and the display mux.
- Keeps N independently scrolling tiled layers. Each layer has its own band, wrap width and speed.
- Drives one external registered ROM per layer. Composites layers by priority with a colour key. Adds a day/night bank toggle.
- Scroll state changes only at frame start, so no tearing.

Parameters:
- N_LAYERS, 2, number of scrolling layers; a higher index is drawn in front.
- X_W, 10, x coordinate width.
- Y_W, 9, y coordinate width.
- ADDR_W, 16, per-layer ROM address width.
- COLOR_W, 12, pixel colour width.
- LAYER_Y0, {10'd400,10'd286}, packed 10-bit per layer: first row of the band.
- LAYER_H, {10'd80,10'd80}, packed 10-bit per layer: band height in rows.
- LAYER_WRAP, {10'd24,10'd278}, packed 10-bit per layer: tile width in pixels.
- LAYER_SPEED, {10'd2,10'd1}, packed 10-bit per layer: pixels advanced per tick; must be less than the wrap width.
- SKY_COLOR, 12'hCC4, colour where no layer is opaque.
- KEY_COLOR, 12'h000, transparent colour key.
- CYCLE_TICKS, 3000, ticks per day/night half-cycle; must be at least 1.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle scroll strobe (100 Hz rate), synchronous to clk.
- game_state  in  2  0 = INITIAL, 1 = PLAYING, 2 = OVER, 3 = treated as OVER.
- pix_valid  in  1  x/y valid this cycle; pixels arrive in raster order.
- x  in  X_W  column.
- y  in  Y_W  row.
- rom_addr  out  N_LAYERS*ADDR_W  per-layer ROM address.
- rom_bank  out  1  0 = day, 1 = night image bank.
- rom_data  in  N_LAYERS*COLOR_W  per-layer ROM data, valid 1 cycle after the address.
- out_valid  out  1  out_data valid.
- out_data  out  COLOR_W  composited pixel.

Behaviour:
- Reset: all offsets 0, night 0, tick counter 0, rom_addr 0, rom_bank 0, out_valid 0, out_data 0. Pipeline valids are cleared.
- Scroll, per layer, on a cycle with tick=1:
  - INITIAL: pending offset ← 0.
  - PLAYING: pending offset ← offset+SPEED, minus WRAP if the sum is ≥ WRAP. The offset therefore stays in [0, WRAP-1]; it never reaches WRAP.
  - OVER: hold.
- Day/night, on tick while PLAYING: counter++. When counter reaches CYCLE_TICKS-1, counter ← 0 and the night flag toggles. INITIAL clears both; OVER holds both.
- Frame latch: on pix_valid with x=0, y=0, each active offset ← pending offset and rom_bank ← night flag.
  - A tick on that same cycle updates pending only. It takes effect at the next frame.
- Address generation (stage 1, registered; no multiplier, no divider):
  - Column phase: at x=0 it loads the active offset. On each later valid pixel it increments, wrapping WRAP-1 → 0.
  - Row base: at x=0, y=Y0 it is 0. At x=0 on each later row inside the band it increases by WRAP.
  - rom_addr = row base + column phase. The layer hit bit is registered alongside: Y0 ≤ y < Y0+H.
  - Outside the band, rom_addr holds its last value and the hit bit is 0.
- Stage 2: the ROM returns data. Hit bits and valid are delayed one cycle to match.
- Stage 3, compositing (registered):
  - Pick the highest-index layer whose hit bit is 1 and whose data ≠ KEY_COLOR.
  - If no layer qualifies, output SKY_COLOR.
- Latency: out_valid and out_data appear exactly 3 cycles after pix_valid; throughput is 1 pixel per cycle.
- pix_valid=0 bubbles propagate with out_valid=0 and do not advance the phase counters.
- Reset mid-frame: pipeline flushed. Output resumes 3 cycles after the first valid pixel after reset. Offsets take effect only from the next (0,0).

Decomposition:
- Package scene_pkg: game_state encodings (GAME_INITIAL, GAME_PLAYING, GAME_OVER), COLOR_W, screen constants (640×480).
- One natural sub-module: scroll_layer_addr, per layer. It holds the offset registers, column phase and row base, and outputs address plus hit. Instantiate it with a generate loop.
- Compositor and day/night logic stay in the top level.

Test Plan:
- Reset, then one full frame in INITIAL with ROMs returning index-encoded data:
  - x=5, y=300 → layer 0 addr (300-286)*278+5 = 3897.
  - x=5, y=100 → out_data 12'hCC4, 3 cycles later.
- PLAYING with 300 ticks then frame start:
  - layer 0 offset = 300 mod 278 = 22; layer 1 offset = 600 mod 24 = 0.
  - Check the x=0 address of each band.
- Layer 1 offset 22, speed 2, one tick → pending 0 (never 24). Mid-frame addresses are unchanged until the next (0,0).
- Layer 1 data = KEY_COLOR at y=420 → out_data = layer 0 data if layer 0 hits there, else SKY_COLOR. With layer 1 opaque, layer 1 wins.
- CYCLE_TICKS=4, 4 ticks PLAYING → night=1; rom_bank=1 only after the next (0,0). Entering OVER freezes offsets and counter; INITIAL clears them.
- Random pix_valid bubbles → out_valid pattern equals pix_valid delayed by 3; assert rst mid-line → out_valid=0 the next cycle.
